// File: rtl/core_boot_pkg.sv
// Shared types and constants for the core boot sequencer.
// Holds the state enum, fill value and run-counter width helper.
package core_boot_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_RELEASE,
    ST_START,
    ST_RUN,
    ST_REPORT,
    ST_DONE,
    ST_ERROR
  } boot_state_t;

  localparam int CLEAR_DATA = 0;

  function automatic int run_cnt_w(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/boot_run_timer.sv
// Loadable down-counter that holds at zero.
// expire is high while the count sits at zero.
module boot_run_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // preset on load, otherwise count down and saturate at zero
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/core_boot_controller.sv
// Boot sequencer: clears and loads ISP memory, releases the core,
// pulses start, waits a fixed run time, pulses report.
module core_boot_controller
  import core_boot_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_BITS  = 12,
  parameter int PROG_ADDR_W   = 20,
  parameter int CLEAR_ON_BOOT = 1,
  parameter int RUN_CYCLES    = 100
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    boot_req,
  input  logic [PROG_ADDR_W-1:0]  boot_prog_address,
  input  logic                    abort,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic                    load_last,
  output logic                    core_reset,
  output logic                    isp_write,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    start,
  output logic [PROG_ADDR_W-1:0]  prog_address,
  output logic                    report,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDRESS_BITS:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDRESS_BITS;
  localparam int CW    = run_cnt_w(RUN_CYCLES);

  localparam logic [CW-1:0] RUN_PRESET =
    CW'(RUN_CYCLES - 1);
  localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = '1;
  localparam logic [ADDRESS_BITS:0] LAST_WORD =
    (ADDRESS_BITS + 1)'(DEPTH - 1);

  boot_state_t state, state_next;

  logic [ADDRESS_BITS-1:0] clr_idx;
  logic                    accept;
  logic                    hs;
  logic                    expire;
  logic                    timer_load;

  assign accept = boot_req & ~abort &
                  (state == ST_IDLE |
                   state == ST_DONE |
                   state == ST_ERROR);

  assign hs = load_valid & load_ready & ~abort;

  // timer is preset so it reaches zero on the last run cycle
  assign timer_load = (state == ST_RELEASE);

  boot_run_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (timer_load),
    .value  (RUN_PRESET),
    .expire (expire)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic; abort overrides everything
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (boot_req) begin
            state_next = (CLEAR_ON_BOOT != 0) ?
                         ST_CLEAR : ST_LOAD;
          end
        end
        ST_CLEAR: begin
          if (clr_idx == LAST_ADDR) begin
            state_next = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (hs) begin
            if (load_last) begin
              state_next = ST_RELEASE;
            end else if (words_loaded == LAST_WORD) begin
              state_next = ST_ERROR;
            end
          end
        end
        ST_RELEASE: state_next = ST_START;
        ST_START, ST_RUN: begin
          state_next = expire ? ST_REPORT : ST_RUN;
        end
        ST_REPORT: state_next = ST_DONE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // zero-fill address walks 0..DEPTH-1 while clearing
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_idx <= '0;
    end else if (accept) begin
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
    end
  end

  // registered outputs decoded from the upcoming state
  always_ff @(posedge clock) begin
    if (reset) begin
      core_reset   <= 1'b1;
      load_ready   <= 1'b0;
      start        <= 1'b0;
      report       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      isp_write    <= 1'b0;
      isp_address  <= '0;
      isp_data     <= '0;
      prog_address <= '0;
      words_loaded <= '0;
    end else begin
      core_reset <= state_next inside
        {ST_IDLE, ST_CLEAR, ST_LOAD, ST_ERROR};
      load_ready <= (state_next == ST_LOAD);
      start      <= (state_next == ST_START);
      report     <= (state_next == ST_REPORT);
      busy       <= !(state_next inside
        {ST_IDLE, ST_DONE, ST_ERROR});
      done       <= (state_next == ST_DONE);
      error      <= (state_next == ST_ERROR);
      isp_write  <= 1'b0;
      if (accept) begin
        prog_address <= boot_prog_address;
        words_loaded <= '0;
      end
      if (!abort && state == ST_CLEAR) begin
        isp_write   <= 1'b1;
        isp_address <= clr_idx;
        isp_data    <= DATA_WIDTH'(CLEAR_DATA);
      end
      if (hs) begin
        isp_write    <= 1'b1;
        isp_address  <= words_loaded[ADDRESS_BITS-1:0];
        isp_data     <= load_data;
        words_loaded <= words_loaded + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_boot_controller.sv
// Scoreboard bench for core_boot_controller.
// Expected ISP writes and pulse timings are queued by the driver.
module tb_core_boot_controller;

  localparam int DW    = 32;
  localparam int AB    = 4;
  localparam int PW    = 20;
  localparam int RC    = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          boot_req = 1'b0;
  logic          abort = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_last = 1'b0;
  logic [PW-1:0] boot_prog_address = '0;
  logic [DW-1:0] load_data = '0;

  logic          load_ready, core_reset, isp_write;
  logic          start, report, busy, done, error;
  logic [AB-1:0] isp_address;
  logic [DW-1:0] isp_data;
  logic [PW-1:0] prog_address;
  logic [AB:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int t;
    int a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    int t;
    logic [PW-1:0] p;
  } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  rq[$];
  int  dq[$];
  int  eq[$];

  wr_t mw;
  st_t ms;
  int  mi;
  logic done_q = 1'b0;
  logic error_q = 1'b0;

  logic [DW-1:0] img [DEPTH];

  core_boot_controller #(
    .DATA_WIDTH    (DW),
    .ADDRESS_BITS  (AB),
    .PROG_ADDR_W   (PW),
    .CLEAR_ON_BOOT (1),
    .RUN_CYCLES    (RC)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .boot_req          (boot_req),
    .boot_prog_address (boot_prog_address),
    .abort             (abort),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_data         (load_data),
    .load_last         (load_last),
    .core_reset        (core_reset),
    .isp_write         (isp_write),
    .isp_address       (isp_address),
    .isp_data          (isp_data),
    .start             (start),
    .prog_address      (prog_address),
    .report            (report),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .words_loaded      (words_loaded)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected or missing event, cycle %0d",
             name, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) img[k] = $urandom;
  endtask

  // monitor: pop and compare whenever the DUT shows an event
  always @(negedge clock) begin
    if (!reset) begin
      if (isp_write) begin
        if (wq.size() == 0) begin
          miss("isp_write");
        end else begin
          mw = wq.pop_front();
          chk("wr_time", 64'(cyc), 64'(mw.t));
          chk("wr_addr", 64'(isp_address), 64'(mw.a));
          chk("wr_data", 64'(isp_data), 64'(mw.d));
        end
      end
      if (start) begin
        if (sq.size() == 0) begin
          miss("start");
        end else begin
          ms = sq.pop_front();
          chk("start_time", 64'(cyc), 64'(ms.t));
          chk("start_prog", 64'(prog_address), 64'(ms.p));
        end
      end
      if (report) begin
        if (rq.size() == 0) begin
          miss("report");
        end else begin
          mi = rq.pop_front();
          chk("report_time", 64'(cyc), 64'(mi));
        end
      end
      if (done && !done_q) begin
        if (dq.size() == 0) begin
          miss("done");
        end else begin
          mi = dq.pop_front();
          chk("done_time", 64'(cyc), 64'(mi));
        end
      end
      if (error && !error_q) begin
        if (eq.size() == 0) begin
          miss("error");
        end else begin
          mi = eq.pop_front();
          chk("error_time", 64'(cyc), 64'(mi));
        end
      end
      done_q = done;
      error_q = error;
    end
  end

  // mode: 0 valid always, 1 every other cycle, 2 random
  task automatic run_boot(input logic [PW-1:0] pa,
                          input int n,
                          input int mode,
                          input bit last,
                          input int abort_after);
    int t0, i, guard, tn;
    bit v, ph;
    boot_req = 1'b1;
    boot_prog_address = pa;
    t0 = cyc;
    tick();
    boot_req = 1'b0;
    chk("core_reset_boot", 64'(core_reset), 64'd1);
    chk("busy_boot", 64'(busy), 64'd1);
    chk("wl_cleared", 64'(words_loaded), 64'd0);
    for (int k = 0; k < DEPTH; k++) begin
      wq.push_back(wr_t'{t0 + 2 + k, k, '0});
    end
    i = 0;
    guard = 0;
    ph = 1'b0;
    tn = -1;
    while (i < n && guard < 200) begin
      if (i == abort_after) begin
        load_valid = 1'b0;
        load_last = 1'b0;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = ph;
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      ph = ~ph;
      load_valid = v;
      load_data = v ? img[i] : $urandom;
      load_last = v && last && (i == n - 1);
      if (v && load_ready) begin
        if (i == 0 && mode == 0) begin
          chk("first_accept", 64'(cyc), 64'(t0 + 1 + DEPTH));
        end
        wq.push_back(wr_t'{cyc + 1, i, img[i]});
        tn = cyc;
        i++;
      end
      tick();
      guard++;
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    if (guard >= 200) miss("load_timeout");
    if (abort_after >= 0) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_isp_write", 64'(isp_write), 64'd0);
      chk("abort_core_reset", 64'(core_reset), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_load_ready", 64'(load_ready), 64'd0);
      chk("abort_wl", 64'(words_loaded), 64'(abort_after));
    end else if (last) begin
      sq.push_back(st_t'{tn + 2, pa});
      rq.push_back(tn + 2 + RC);
      dq.push_back(tn + 3 + RC);
      chk("release_core_reset", 64'(core_reset), 64'd0);
      guard = 0;
      while (!done && guard < RC + 20) begin
        tick();
        guard++;
      end
      if (!done) miss("done_timeout");
      chk("done_level", 64'(done), 64'd1);
      chk("done_wl", 64'(words_loaded), 64'(n));
      chk("done_prog", 64'(prog_address), 64'(pa));
      chk("done_core_reset", 64'(core_reset), 64'd0);
      chk("done_busy", 64'(busy), 64'd0);
    end else begin
      eq.push_back(tn + 1);
      chk("err_level", 64'(error), 64'd1);
      chk("err_core_reset", 64'(core_reset), 64'd1);
      chk("err_wl", 64'(words_loaded), 64'(n));
      repeat (RC + 4) tick();
      chk("err_hold", 64'(error), 64'd1);
      chk("err_hold_reset", 64'(core_reset), 64'd1);
      chk("err_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    chk("rst_isp_write", 64'(isp_write), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_report", 64'(report), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_isp_address", 64'(isp_address), 64'd0);
    chk("rst_isp_data", 64'(isp_data), 64'd0);
    chk("rst_prog", 64'(prog_address), 64'd0);
    chk("rst_wl", 64'(words_loaded), 64'd0);

    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    img[2] = 32'h0000_006f;
    run_boot(20'h00000, 3, 0, 1'b1, -1);

    fill_random(5);
    run_boot(20'h00040, 5, 1, 1'b1, -1);

    fill_random(DEPTH);
    run_boot(PW'($urandom), 1 + $urandom_range(0, 8), 2, 1'b1, -1);

    fill_random(DEPTH);
    run_boot(20'h00010, DEPTH, 0, 1'b1, -1);

    fill_random(DEPTH);
    run_boot(20'h0abcd, DEPTH, 0, 1'b0, -1);

    fill_random(DEPTH);
    run_boot(20'h00123, 6, 0, 1'b1, 2);

    boot_req = 1'b1;
    abort = 1'b1;
    tick();
    boot_req = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", 64'(busy), 64'd0);
    chk("abort_wins_reset", 64'(core_reset), 64'd1);
    chk("abort_wins_ready", 64'(load_ready), 64'd0);
    repeat (3) tick();

    fill_random(DEPTH);
    run_boot(20'h00777, 4, 2, 1'b1, -1);
    repeat (4) tick();

    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("sq_empty", 64'(sq.size()), 64'd0);
    chk("rq_empty", 64'(rq.size()), 64'd0);
    chk("dq_empty", 64'(dq.size()), 64'd0);
    chk("eq_empty", 64'(eq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
